// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor.
// Adds two N-bit operands D bits per clock through a single D-bit adder
// slice. The carry between digits lives in a register. A start/done
// handshake connects the block to its controlling FSM.
// Optional feature: define OVERFLOW_EN to add the signed-overflow output ovf.
module digit_serial_adder #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef OVERFLOW_EN
   ,output logic         ovf
`endif
);

    localparam int DIGITS = N / D;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Reject any width combination that does not divide into whole digits.
    generate
        if (D < 1 || D > N || (N % D) != 0) begin : g_bad_param
            $error("digit_serial_adder: need 1 <= D <= N and N %% D == 0");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       res_q, res_d;
    logic [N-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef OVERFLOW_EN
    logic               ovf_q, ovf_d;
    logic               ovf_next;
`endif

    logic               accept;
    logic               last_digit;
    logic [D:0]         slice;
    logic [N+D-1:0]     res_cat;
    logic [N-1:0]       res_next;

    // Adder slice: low digit of each operand plus the carry, and the result
    // shift register after this digit's bits are pushed in at the top.
    always_comb begin
        slice      = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};
        res_cat    = {slice[D-1:0], res_q};
        res_next   = res_cat[N+D-1:D];
        last_digit = (cnt_q == CNT_W'(DIGITS - 1));
        // A new request is taken in IDLE and also in DONE, so back-to-back
        // operations lose no cycle. A request during RUN is dropped.
        accept     = start && (state_q != S_RUN);
`ifdef OVERFLOW_EN
        // On the last digit, slice bit D-1 is the operand MSB. The carry into
        // that bit is a^b^s, and the carry out of it is slice[D].
        ovf_next   = a_q[D-1] ^ b_q[D-1] ^ slice[D-1] ^ slice[D];
`endif
    end

    // Next-state logic for the IDLE / RUN / DONE sequencer.
    always_comb begin
        // NOTE: default assignment first so that no path leaves state_d unassigned (avoids an inferred latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one digit per RUN cycle,
    // publish the result on the final digit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            // Subtraction is A + ~B + 1, so B is inverted and the carry is forced to 1.
            a_d     = A;
            b_d     = B ^ {N{sub}};
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> D;
            b_d     = b_q >> D;
            carry_d = slice[D];
            cnt_d   = cnt_q + CNT_W'(1);
            res_d   = res_next;
            if (last_digit) begin
                sum_d  = res_next;
                cout_d = slice[D];
`ifdef OVERFLOW_EN
                ovf_d  = ovf_next;
`endif
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            state_q <= state_d;
        end
    end

    // Datapath registers. Everything is cleared so an abandoned op leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Outputs: the handshake is decoded from state, and results come straight from their registers.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef OVERFLOW_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed testbench for digit_serial_adder. It runs three instances with
// N=8: D=2 (main), D=1 and D=8. Build with OVERFLOW_EN defined to also
// cover ovf.
module tb_digit_serial_adder;

    logic       clk;
    logic       rst_n;
    logic [2:0] start;
    logic       sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;

    wire        busy_w [3];
    wire        done_w [3];
    wire  [7:0] sum_w  [3];
    wire        cout_w [3];
    wire        ovf_w  [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] last_sum [3];

`ifndef OVERFLOW_EN
    assign ovf_w[0] = 1'b0;
    assign ovf_w[1] = 1'b0;
    assign ovf_w[2] = 1'b0;
`endif

    digit_serial_adder #(.N(8), .D(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .A(A), .B(B), .cin(cin),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0])
`ifdef OVERFLOW_EN
       ,.ovf(ovf_w[0])
`endif
    );

    digit_serial_adder #(.N(8), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .A(A), .B(B), .cin(cin),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1])
`ifdef OVERFLOW_EN
       ,.ovf(ovf_w[1])
`endif
    );

    digit_serial_adder #(.N(8), .D(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .A(A), .B(B), .cin(cin),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2])
`ifdef OVERFLOW_EN
       ,.ovf(ovf_w[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run one operation on instance sel. Check the busy length, the sum hold
    // during RUN, the result, and that done lasts a single cycle.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input logic [7:0] es,
                          input logic ec, input logic eo, input int lat, input string tag);
        int  nb;
        bit  seen;
        A = a; B = b; cin = c; sub = s;
        start[sel] = 1'b1;
        cyc();
        start[sel] = 1'b0;
        A = ~a; B = ~b; cin = ~c; sub = ~s;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_w[sel]) seen = 1'b1;
            else begin
                if (busy_w[sel]) nb++;
                if (nb == 1) check({tag, "_sum_hold"}, sum_w[sel], last_sum[sel]);
                cyc();
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_busy_cycles"}, nb, lat);
        check({tag, "_sum"}, sum_w[sel], es);
        check({tag, "_cout"}, cout_w[sel], ec);
`ifdef OVERFLOW_EN
        check({tag, "_ovf"}, ovf_w[sel], eo);
`else
        if (eo === 1'bx) check({tag, "_ovf_unused"}, eo, 0);
`endif
        last_sum[sel] = es;
        cyc();
        check({tag, "_done_pulse"}, done_w[sel], 0);
    endtask

    initial begin : main
        int  n;
        bit  seen;
        for (int i = 0; i < 3; i++) last_sum[i] = 8'h00;
        rst_n = 1'b0; start = 3'b000; sub = 1'b0; A = 8'h00; B = 8'h00; cin = 1'b0;
        #12;
        check("rst_busy", busy_w[0], 0);
        check("rst_done", done_w[0], 0);
        check("rst_sum",  sum_w[0],  0);
        check("rst_cout", cout_w[0], 0);
        check("rst_ovf",  ovf_w[0],  0);
        rst_n = 1'b1;
        cyc();

        // Basic add, carry boundaries, subtract (cin ignored), and overflow corners.
        run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 4, "add_5a_3c");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4, "add_ff_01");
        run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 4, "add_cin");
        run_op(0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 4, "sub_10_01");
        run_op(0, 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4, "sub_01_02");
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 4, "ovf_add");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 4, "ovf_sub");

        // start during RUN is ignored; start held into DONE begins the next op back-to-back.
        A = 8'h5A; B = 8'h3C; cin = 1'b0; sub = 1'b0; start[0] = 1'b1;
        cyc();
        A = 8'h11; B = 8'h22;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done_w[0]) seen = 1'b1;
            else begin cyc(); n++; end
        end
        check("b2b_first_done", seen, 1);
        check("b2b_first_lat", n, 4);
        check("b2b_first_sum", sum_w[0], 8'h96);
        cyc();
        start[0] = 1'b0;
        check("b2b_restart_busy", busy_w[0], 1);
        n = 1; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done_w[0]) seen = 1'b1;
            else begin cyc(); n++; end
        end
        check("b2b_second_done", seen, 1);
        check("b2b_second_gap", n, 5);
        check("b2b_second_sum", sum_w[0], 8'h33);
        check("b2b_second_cout", cout_w[0], 0);
        last_sum[0] = 8'h33;
        cyc();

        // Reset at RUN cycle 2 abandons the op at once and produces no done.
        A = 8'hFF; B = 8'h01; cin = 1'b0; sub = 1'b0; start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_w[0], 0);
        check("midrst_sum",  sum_w[0],  0);
        check("midrst_cout", cout_w[0], 0);
        cyc();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done_w[0] || busy_w[0]) seen = 1'b1;
            cyc();
        end
        check("midrst_no_done", seen, 0);
        for (int i = 0; i < 3; i++) last_sum[i] = 8'h00;
        run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 4, "post_rst");

        // The same add on the D=1 and D=8 instances.
        run_op(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8, "d1_add");
        run_op(2, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1, "d8_add");
        run_op(2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1, "d8_sub");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
